exponent_axi4_lite_master: RTL and testbench

AXI4-Lite initiator that drives the exponent accelerator's AXI4-Lite register slave from a simple valid/ready command port. For each command it writes the operand, writes the start bit, polls status until done, reads the result, and returns it on a valid/ready response port. It replaces software register banging in self-test and DMA-less datapaths.

---
 rtl/exponent_axi_pkg.sv | 49 ++++
 rtl/exponent_axi4_lite_master_txn.sv | 159 +++++++++++++++
 rtl/exponent_axi4_lite_master.sv | 232 +++++++++++++++++++++++
 tb/tb_exponent_axi4_lite_master.sv | 333 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/exponent_axi_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : exponent_axi_pkg
//  Description : Shared definitions for the exponent AXI4-Lite initiator:
//                slave register map, control/status bit positions, FSM state
//                encodings, response codes and AXI response encoding.
//  Revision    : 1.0  initial release
// ============================================================================
package exponent_axi_pkg;

    // Register offsets relative to the exponent slave base address
    localparam logic [7:0] c_OFS_OPERAND = 8'h00;
    localparam logic [7:0] c_OFS_CONTROL = 8'h04;
    localparam logic [7:0] c_OFS_STATUS  = 8'h08;
    localparam logic [7:0] c_OFS_RESULT  = 8'h0C;

    // Bit positions inside the control and status registers
    localparam int c_CTRL_START_BIT = 0;
    localparam int c_STAT_DONE_BIT  = 0;

    // Response codes returned on the command response port
    localparam logic [1:0] c_RSP_OKAY    = 2'b00;
    localparam logic [1:0] c_RSP_BUSERR  = 2'b01;
    localparam logic [1:0] c_RSP_TIMEOUT = 2'b10;

    // AXI BRESP/RRESP encoding for a successful access
    localparam logic [1:0] c_AXI_OKAY = 2'b00;

    // Command sequencer states
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WR_OP   = 3'd1,
        ST_WR_CTRL = 3'd2,
        ST_RD_STAT = 3'd3,
        ST_RD_RES  = 3'd4,
        ST_RESP    = 3'd5
    } state_t;

    // Single-transaction engine states
    typedef enum logic [2:0] {
        TX_IDLE  = 3'd0,
        TX_WADDR = 3'd1,
        TX_WRESP = 3'd2,
        TX_RADDR = 3'd3,
        TX_RDATA = 3'd4
    } txn_state_t;

endpackage : exponent_axi_pkg
`default_nettype wire

// File: rtl/exponent_axi4_lite_master_txn.sv
`default_nettype none
// ============================================================================
//  Module      : exponent_axi4_lite_master_txn
//  Description : Single AXI4-Lite transaction engine. A one-cycle i_start
//                launches either a write (AW+W, then B) or a read (AR, then R).
//                o_done pulses combinationally in the cycle the response
//                handshake completes, with o_resp/o_rdata valid alongside, so
//                the sequencer can launch the next access on that same edge.
//  Ports       : clk, rst_n               clock, async active-low reset
//                i_start/i_write/i_addr/i_wdata  transaction request
//                o_done/o_resp/o_rdata    completion, response, read data
//                o_aw*/o_w*/o_bready/o_ar*/o_rready, i_*   AXI4-Lite master
//  Revision    : 1.0  initial release
// ============================================================================
module exponent_axi4_lite_master_txn
    import exponent_axi_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_start,
    input  logic              i_write,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [DATA_W-1:0] i_wdata,
    output logic              o_done,
    output logic [1:0]        o_resp,
    output logic [DATA_W-1:0] o_rdata,
    output logic [ADDR_W-1:0] o_awaddr,
    output logic              o_awvalid,
    input  logic              i_awready,
    output logic [DATA_W-1:0] o_wdata,
    output logic              o_wvalid,
    input  logic              i_wready,
    input  logic [1:0]        i_bresp,
    input  logic              i_bvalid,
    output logic              o_bready,
    output logic [ADDR_W-1:0] o_araddr,
    output logic              o_arvalid,
    input  logic              i_arready,
    input  logic [DATA_W-1:0] i_rdata,
    input  logic [1:0]        i_rresp,
    input  logic              i_rvalid,
    output logic              o_rready
);

    txn_state_t        r_state, w_state_nxt;
    logic [ADDR_W-1:0] r_awaddr, w_awaddr_nxt;
    logic [ADDR_W-1:0] r_araddr, w_araddr_nxt;
    logic [DATA_W-1:0] r_wdata, w_wdata_nxt;
    logic              r_awvalid, w_awvalid_nxt;
    logic              r_wvalid, w_wvalid_nxt;
    logic              r_bready, w_bready_nxt;
    logic              r_arvalid, w_arvalid_nxt;
    logic              r_rready, w_rready_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= TX_IDLE;
            r_awaddr  <= '0;
            r_araddr  <= '0;
            r_wdata   <= '0;
            r_awvalid <= 1'b0;
            r_wvalid  <= 1'b0;
            r_bready  <= 1'b0;
            r_arvalid <= 1'b0;
            r_rready  <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_awaddr  <= w_awaddr_nxt;
            r_araddr  <= w_araddr_nxt;
            r_wdata   <= w_wdata_nxt;
            r_awvalid <= w_awvalid_nxt;
            r_wvalid  <= w_wvalid_nxt;
            r_bready  <= w_bready_nxt;
            r_arvalid <= w_arvalid_nxt;
            r_rready  <= w_rready_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_awaddr_nxt  = r_awaddr;
        w_araddr_nxt  = r_araddr;
        w_wdata_nxt   = r_wdata;
        w_awvalid_nxt = r_awvalid;
        w_wvalid_nxt  = r_wvalid;
        w_bready_nxt  = r_bready;
        w_arvalid_nxt = r_arvalid;
        w_rready_nxt  = r_rready;

        case (r_state)
            TX_IDLE: begin
            end
            TX_WADDR: begin
                // AW and W retire independently; B is only accepted once both have
                w_awvalid_nxt = r_awvalid & ~i_awready;
                w_wvalid_nxt  = r_wvalid & ~i_wready;
                if (!w_awvalid_nxt && !w_wvalid_nxt) begin
                    w_bready_nxt = 1'b1;
                    w_state_nxt  = TX_WRESP;
                end
            end
            TX_WRESP: begin
                if (i_bvalid) begin
                    w_bready_nxt = 1'b0;
                    w_state_nxt  = TX_IDLE;
                end
            end
            TX_RADDR: begin
                if (i_arready) begin
                    w_arvalid_nxt = 1'b0;
                    w_rready_nxt  = 1'b1;
                    w_state_nxt   = TX_RDATA;
                end
            end
            TX_RDATA: begin
                if (i_rvalid) begin
                    w_rready_nxt = 1'b0;
                    w_state_nxt  = TX_IDLE;
                end
            end
            default: w_state_nxt = TX_IDLE;
        endcase

        // A new request may coincide with the previous response handshake,
        // so it overrides whatever the case above decided.
        if (i_start) begin
            w_bready_nxt = 1'b0;
            w_rready_nxt = 1'b0;
            if (i_write) begin
                w_awaddr_nxt  = i_addr;
                w_wdata_nxt   = i_wdata;
                w_awvalid_nxt = 1'b1;
                w_wvalid_nxt  = 1'b1;
                w_state_nxt   = TX_WADDR;
            end else begin
                w_araddr_nxt  = i_addr;
                w_arvalid_nxt = 1'b1;
                w_state_nxt   = TX_RADDR;
            end
        end
    end

    assign o_done    = (r_bready & i_bvalid) | (r_rready & i_rvalid);
    assign o_resp    = r_rready ? i_rresp : i_bresp;
    assign o_rdata   = i_rdata;
    assign o_awaddr  = r_awaddr;
    assign o_awvalid = r_awvalid;
    assign o_wdata   = r_wdata;
    assign o_wvalid  = r_wvalid;
    assign o_bready  = r_bready;
    assign o_araddr  = r_araddr;
    assign o_arvalid = r_arvalid;
    assign o_rready  = r_rready;

endmodule : exponent_axi4_lite_master_txn
`default_nettype wire

// File: rtl/exponent_axi4_lite_master.sv
`default_nettype none
// ============================================================================
//  Module      : exponent_axi4_lite_master
//  Description : Command-driven AXI4-Lite initiator for the exponent
//                accelerator. Per command: write operand, write start bit,
//                poll status until done (bounded by C_POLL_LIMIT), read the
//                result, and present it on the response port.
//  Ports       : M_AXI_ACLK / M_AXI_ARESETN  clock, async active-low reset
//                cmd_valid/cmd_ready/cmd_operand          command port
//                rsp_valid/rsp_ready/rsp_result/rsp_code  response port
//                M_AXI_*                                  AXI4-Lite master
//  Revision    : 1.0  initial release
// ============================================================================
module exponent_axi4_lite_master
    import exponent_axi_pkg::*;
#(
    parameter int                            C_M_AXI_ADDR_WIDTH = 32,
    parameter int                            C_M_AXI_DATA_WIDTH = 32,
    parameter logic [C_M_AXI_ADDR_WIDTH-1:0] C_TARGET_BASEADDR  = 32'h7c800000,
    parameter int                            C_POLL_LIMIT       = 255
) (
    input  logic                            M_AXI_ACLK,
    input  logic                            M_AXI_ARESETN,
    input  logic                            cmd_valid,
    output logic                            cmd_ready,
    input  logic [31:0]                     cmd_operand,
    output logic                            rsp_valid,
    input  logic                            rsp_ready,
    output logic [31:0]                     rsp_result,
    output logic [1:0]                      rsp_code,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_AWADDR,
    output logic                            M_AXI_AWVALID,
    input  logic                            M_AXI_AWREADY,
    output logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_WDATA,
    output logic [C_M_AXI_DATA_WIDTH/8-1:0] M_AXI_WSTRB,
    output logic                            M_AXI_WVALID,
    input  logic                            M_AXI_WREADY,
    input  logic [1:0]                      M_AXI_BRESP,
    input  logic                            M_AXI_BVALID,
    output logic                            M_AXI_BREADY,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_ARADDR,
    output logic                            M_AXI_ARVALID,
    input  logic                            M_AXI_ARREADY,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_RDATA,
    input  logic [1:0]                      M_AXI_RRESP,
    input  logic                            M_AXI_RVALID,
    output logic                            M_AXI_RREADY
);

    localparam logic [C_M_AXI_ADDR_WIDTH-1:0] c_ADDR_OPERAND =
        C_TARGET_BASEADDR + C_M_AXI_ADDR_WIDTH'(c_OFS_OPERAND);
    localparam logic [C_M_AXI_ADDR_WIDTH-1:0] c_ADDR_CONTROL =
        C_TARGET_BASEADDR + C_M_AXI_ADDR_WIDTH'(c_OFS_CONTROL);
    localparam logic [C_M_AXI_ADDR_WIDTH-1:0] c_ADDR_STATUS  =
        C_TARGET_BASEADDR + C_M_AXI_ADDR_WIDTH'(c_OFS_STATUS);
    localparam logic [C_M_AXI_ADDR_WIDTH-1:0] c_ADDR_RESULT  =
        C_TARGET_BASEADDR + C_M_AXI_ADDR_WIDTH'(c_OFS_RESULT);

    state_t                          r_state, w_state_nxt;
    logic [15:0]                     r_poll_cnt, w_poll_nxt;
    logic [31:0]                     r_rsp_result, w_result_nxt;
    logic [1:0]                      r_rsp_code, w_code_nxt;
    logic                            r_cmd_ready;
    logic                            r_rsp_valid;

    logic                            w_txn_start;
    logic                            w_txn_write;
    logic [C_M_AXI_ADDR_WIDTH-1:0]   w_txn_addr;
    logic [C_M_AXI_DATA_WIDTH-1:0]   w_txn_wdata;
    logic                            w_txn_done;
    logic [1:0]                      w_txn_resp;
    logic [C_M_AXI_DATA_WIDTH-1:0]   w_txn_rdata;
    logic                            w_txn_ok;
    logic [16:0]                     w_poll_inc;

    assign w_txn_ok   = (w_txn_resp == c_AXI_OKAY);
    assign w_poll_inc = {1'b0, r_poll_cnt} + 17'd1;

    always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
        if (!M_AXI_ARESETN) begin
            r_state      <= ST_IDLE;
            r_poll_cnt   <= '0;
            r_rsp_result <= '0;
            r_rsp_code   <= c_RSP_OKAY;
            r_cmd_ready  <= 1'b0;
            r_rsp_valid  <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_poll_cnt   <= w_poll_nxt;
            r_rsp_result <= w_result_nxt;
            r_rsp_code   <= w_code_nxt;
            // Handshake flags are registered from the next state so they stay
            // low throughout reset and track the state with no glitches.
            r_cmd_ready  <= (w_state_nxt == ST_IDLE);
            r_rsp_valid  <= (w_state_nxt == ST_RESP);
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_poll_nxt   = r_poll_cnt;
        w_result_nxt = r_rsp_result;
        w_code_nxt   = r_rsp_code;
        w_txn_start  = 1'b0;
        w_txn_write  = 1'b0;
        w_txn_addr   = c_ADDR_OPERAND;
        w_txn_wdata  = '0;

        case (r_state)
            ST_IDLE: begin
                if (cmd_valid && r_cmd_ready) begin
                    // The operand is captured straight into the engine's WDATA register
                    w_txn_start  = 1'b1;
                    w_txn_write  = 1'b1;
                    w_txn_addr   = c_ADDR_OPERAND;
                    w_txn_wdata  = cmd_operand;
                    w_poll_nxt   = '0;
                    w_result_nxt = '0;
                    w_code_nxt   = c_RSP_OKAY;
                    w_state_nxt  = ST_WR_OP;
                end
            end
            ST_WR_OP: begin
                if (w_txn_done) begin
                    if (!w_txn_ok) begin
                        w_code_nxt   = c_RSP_BUSERR;
                        w_result_nxt = '0;
                        w_state_nxt  = ST_RESP;
                    end else begin
                        w_txn_start                   = 1'b1;
                        w_txn_write                   = 1'b1;
                        w_txn_addr                    = c_ADDR_CONTROL;
                        w_txn_wdata[c_CTRL_START_BIT] = 1'b1;
                        w_state_nxt                   = ST_WR_CTRL;
                    end
                end
            end
            ST_WR_CTRL: begin
                if (w_txn_done) begin
                    if (!w_txn_ok) begin
                        w_code_nxt   = c_RSP_BUSERR;
                        w_result_nxt = '0;
                        w_state_nxt  = ST_RESP;
                    end else begin
                        w_txn_start = 1'b1;
                        w_txn_addr  = c_ADDR_STATUS;
                        w_state_nxt = ST_RD_STAT;
                    end
                end
            end
            ST_RD_STAT: begin
                if (w_txn_done) begin
                    if (!w_txn_ok) begin
                        w_code_nxt   = c_RSP_BUSERR;
                        w_result_nxt = '0;
                        w_state_nxt  = ST_RESP;
                    end else if (w_txn_rdata[c_STAT_DONE_BIT]) begin
                        w_txn_start = 1'b1;
                        w_txn_addr  = c_ADDR_RESULT;
                        w_state_nxt = ST_RD_RES;
                    end else if (w_poll_inc == 17'(C_POLL_LIMIT)) begin
                        // This read was the last one allowed
                        w_code_nxt   = c_RSP_TIMEOUT;
                        w_result_nxt = '0;
                        w_state_nxt  = ST_RESP;
                    end else begin
                        w_poll_nxt  = w_poll_inc[15:0];
                        w_txn_start = 1'b1;
                        w_txn_addr  = c_ADDR_STATUS;
                    end
                end
            end
            ST_RD_RES: begin
                if (w_txn_done) begin
                    if (!w_txn_ok) begin
                        w_code_nxt   = c_RSP_BUSERR;
                        w_result_nxt = '0;
                    end else begin
                        w_code_nxt   = c_RSP_OKAY;
                        w_result_nxt = w_txn_rdata;
                    end
                    w_state_nxt = ST_RESP;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    exponent_axi4_lite_master_txn #(
        .ADDR_W (C_M_AXI_ADDR_WIDTH),
        .DATA_W (C_M_AXI_DATA_WIDTH)
    ) u_txn (
        .clk       (M_AXI_ACLK),
        .rst_n     (M_AXI_ARESETN),
        .i_start   (w_txn_start),
        .i_write   (w_txn_write),
        .i_addr    (w_txn_addr),
        .i_wdata   (w_txn_wdata),
        .o_done    (w_txn_done),
        .o_resp    (w_txn_resp),
        .o_rdata   (w_txn_rdata),
        .o_awaddr  (M_AXI_AWADDR),
        .o_awvalid (M_AXI_AWVALID),
        .i_awready (M_AXI_AWREADY),
        .o_wdata   (M_AXI_WDATA),
        .o_wvalid  (M_AXI_WVALID),
        .i_wready  (M_AXI_WREADY),
        .i_bresp   (M_AXI_BRESP),
        .i_bvalid  (M_AXI_BVALID),
        .o_bready  (M_AXI_BREADY),
        .o_araddr  (M_AXI_ARADDR),
        .o_arvalid (M_AXI_ARVALID),
        .i_arready (M_AXI_ARREADY),
        .i_rdata   (M_AXI_RDATA),
        .i_rresp   (M_AXI_RRESP),
        .i_rvalid  (M_AXI_RVALID),
        .o_rready  (M_AXI_RREADY)
    );

    assign cmd_ready   = r_cmd_ready;
    assign rsp_valid   = r_rsp_valid;
    assign rsp_result  = r_rsp_result;
    assign rsp_code    = r_rsp_code;
    assign M_AXI_WSTRB = '1;

endmodule : exponent_axi4_lite_master
`default_nettype wire

// File: tb/tb_exponent_axi4_lite_master.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_exponent_axi4_lite_master
//  Description : Self-checking bench with a configurable AXI4-Lite responder
//                model and a result/code scoreboard.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_exponent_axi4_lite_master;

    localparam logic [31:0] c_BASE       = 32'h7c800000;
    localparam int          c_POLL_LIMIT = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [31:0] cmd_operand = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_result;
    logic [1:0]  rsp_code;
    logic [31:0] M_AXI_AWADDR;
    logic        M_AXI_AWVALID;
    logic        M_AXI_AWREADY = 1'b0;
    logic [31:0] M_AXI_WDATA;
    logic [3:0]  M_AXI_WSTRB;
    logic        M_AXI_WVALID;
    logic        M_AXI_WREADY = 1'b0;
    logic [1:0]  M_AXI_BRESP = 2'b00;
    logic        M_AXI_BVALID = 1'b0;
    logic        M_AXI_BREADY;
    logic [31:0] M_AXI_ARADDR;
    logic        M_AXI_ARVALID;
    logic        M_AXI_ARREADY = 1'b0;
    logic [31:0] M_AXI_RDATA = '0;
    logic [1:0]  M_AXI_RRESP = 2'b00;
    logic        M_AXI_RVALID = 1'b0;
    logic        M_AXI_RREADY;

    always #5 clk = ~clk;

    exponent_axi4_lite_master #(
        .C_M_AXI_ADDR_WIDTH (32),
        .C_M_AXI_DATA_WIDTH (32),
        .C_TARGET_BASEADDR  (c_BASE),
        .C_POLL_LIMIT       (c_POLL_LIMIT)
    ) dut (
        .M_AXI_ACLK    (clk),
        .M_AXI_ARESETN (rst_n),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_operand   (cmd_operand),
        .rsp_valid     (rsp_valid),
        .rsp_ready     (rsp_ready),
        .rsp_result    (rsp_result),
        .rsp_code      (rsp_code),
        .M_AXI_AWADDR  (M_AXI_AWADDR),
        .M_AXI_AWVALID (M_AXI_AWVALID),
        .M_AXI_AWREADY (M_AXI_AWREADY),
        .M_AXI_WDATA   (M_AXI_WDATA),
        .M_AXI_WSTRB   (M_AXI_WSTRB),
        .M_AXI_WVALID  (M_AXI_WVALID),
        .M_AXI_WREADY  (M_AXI_WREADY),
        .M_AXI_BRESP   (M_AXI_BRESP),
        .M_AXI_BVALID  (M_AXI_BVALID),
        .M_AXI_BREADY  (M_AXI_BREADY),
        .M_AXI_ARADDR  (M_AXI_ARADDR),
        .M_AXI_ARVALID (M_AXI_ARVALID),
        .M_AXI_ARREADY (M_AXI_ARREADY),
        .M_AXI_RDATA   (M_AXI_RDATA),
        .M_AXI_RRESP   (M_AXI_RRESP),
        .M_AXI_RVALID  (M_AXI_RVALID),
        .M_AXI_RREADY  (M_AXI_RREADY)
    );

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    typedef struct packed {
        logic [31:0] result;
        logic [1:0]  code;
    } exp_t;
    exp_t sb[$];

    // ---------------- responder model ----------------
    int          cyc = 0;
    int          aw_delay = 0, w_delay = 0, aw_wait = 0, w_wait = 0;
    int          done_on = 1;     // status read number that reports done; 0 = never
    int          stat_reads = 0;
    bit          bresp_err_op = 1'b0;
    logic [31:0] result_val = '0;
    logic        aw_have = 0, w_have = 0, b_pending = 0, r_pending = 0;
    logic [31:0] aw_addr_q = '0, w_data_q = '0, r_data_q = '0;
    logic [1:0]  b_resp_q = 2'b00;
    logic [31:0] wr_addr_log[$];
    logic [31:0] wr_data_log[$];
    int          viol = 0;
    logic        pv_aw = 0, pv_w = 0, pv_ar = 0;
    logic [31:0] pv_awaddr = '0, pv_wdata = '0, pv_araddr = '0;

    function automatic exp_t model(input logic [31:0] res);
        exp_t e;
        if (bresp_err_op)                              e = '{result: 32'h0, code: 2'b01};
        else if (done_on == 0 || done_on > c_POLL_LIMIT) e = '{result: 32'h0, code: 2'b10};
        else                                           e = '{result: res,   code: 2'b00};
        return e;
    endfunction

    // Handshakes happen at the rising edge: record them and watch protocol rules
    always @(posedge clk) begin
        cyc++;
        if (!rst_n) begin
            aw_have = 0; w_have = 0; b_pending = 0; r_pending = 0;
            pv_aw = 0; pv_w = 0; pv_ar = 0;
        end else begin
            if (pv_aw && (!M_AXI_AWVALID || M_AXI_AWADDR !== pv_awaddr)) viol++;
            if (pv_w  && (!M_AXI_WVALID  || M_AXI_WDATA  !== pv_wdata))  viol++;
            if (pv_ar && (!M_AXI_ARVALID || M_AXI_ARADDR !== pv_araddr)) viol++;
            if ((M_AXI_AWVALID || M_AXI_WVALID || M_AXI_BREADY) &&
                (M_AXI_ARVALID || M_AXI_RREADY)) viol++;
            pv_aw = M_AXI_AWVALID && !M_AXI_AWREADY; pv_awaddr = M_AXI_AWADDR;
            pv_w  = M_AXI_WVALID  && !M_AXI_WREADY;  pv_wdata  = M_AXI_WDATA;
            pv_ar = M_AXI_ARVALID && !M_AXI_ARREADY; pv_araddr = M_AXI_ARADDR;

            if (M_AXI_BVALID && M_AXI_BREADY) b_pending = 0;
            if (M_AXI_RVALID && M_AXI_RREADY) r_pending = 0;
            if (M_AXI_AWVALID && M_AXI_AWREADY) begin aw_addr_q = M_AXI_AWADDR; aw_have = 1; end
            if (M_AXI_WVALID && M_AXI_WREADY)   begin w_data_q  = M_AXI_WDATA;  w_have  = 1; end
            if (aw_have && w_have) begin
                wr_addr_log.push_back(aw_addr_q);
                wr_data_log.push_back(w_data_q);
                b_resp_q  = (bresp_err_op && aw_addr_q == c_BASE) ? 2'b10 : 2'b00;
                b_pending = 1;
                aw_have = 0; w_have = 0;
            end
            if (M_AXI_ARVALID && M_AXI_ARREADY) begin
                r_pending = 1;
                if (M_AXI_ARADDR == c_BASE + 32'h8) begin
                    stat_reads++;
                    r_data_q = (done_on != 0 && stat_reads >= done_on) ? 32'h1 : 32'h0;
                end else if (M_AXI_ARADDR == c_BASE + 32'hC) begin
                    r_data_q = result_val;
                end else begin
                    r_data_q = 32'hDEAD_BEEF;
                end
            end
        end
    end

    // Responder outputs change on the falling edge
    always @(negedge clk) begin
        if (!rst_n) begin
            M_AXI_AWREADY = 0; M_AXI_WREADY = 0; M_AXI_ARREADY = 0;
            M_AXI_BVALID = 0; M_AXI_RVALID = 0; M_AXI_RDATA = '0;
            aw_wait = 0; w_wait = 0;
        end else begin
            if (M_AXI_AWVALID) begin
                if (aw_wait >= aw_delay) M_AXI_AWREADY = 1;
                else begin M_AXI_AWREADY = 0; aw_wait++; end
            end else begin M_AXI_AWREADY = 0; aw_wait = 0; end
            if (M_AXI_WVALID) begin
                if (w_wait >= w_delay) M_AXI_WREADY = 1;
                else begin M_AXI_WREADY = 0; w_wait++; end
            end else begin M_AXI_WREADY = 0; w_wait = 0; end
            M_AXI_ARREADY = M_AXI_ARVALID;
            M_AXI_BVALID  = b_pending;
            M_AXI_BRESP   = b_resp_q;
            M_AXI_RVALID  = r_pending;
            M_AXI_RDATA   = r_pending ? r_data_q : 32'h0;
            M_AXI_RRESP   = 2'b00;
        end
    end

    // ---------------- command / response helpers (called at a falling edge) ----------------
    task automatic start_cmd(input logic [31:0] op, output int t0);
        int n = 0;
        cmd_valid   = 1'b1;
        cmd_operand = op;
        while (!cmd_ready && n < 100) begin @(negedge clk); n++; end
        check_eq("cmd_accepted", cmd_ready, 1);
        t0 = cyc;
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_rsp(output int t1);
        int   n = 0;
        exp_t e;
        while (!rsp_valid && n < 300) begin @(negedge clk); n++; end
        check_eq("rsp_valid_seen", rsp_valid, 1);
        t1 = cyc;
        check_eq("sb_nonempty", sb.size() != 0, 1);
        if (sb.size() != 0) begin
            e = sb.pop_front();
            check_eq("rsp_result", rsp_result, e.result);
            check_eq("rsp_code", rsp_code, e.code);
        end
    endtask

    task automatic release_rsp();
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
    endtask

    task automatic clear_log();
        wr_addr_log.delete();
        wr_data_log.delete();
        stat_reads = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0, t1, bad, n;
        repeat (3) @(negedge clk);
        // Reset values
        check_eq("rst_valids", {M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY,
                                M_AXI_ARVALID, M_AXI_RREADY, cmd_ready, rsp_valid}, 0);
        check_eq("rst_rsp", {rsp_result, rsp_code}, 0);
        check_eq("rst_addr_data", {M_AXI_AWADDR, M_AXI_WDATA}, 0);
        check_eq("rst_araddr", M_AXI_ARADDR, 0);
        check_eq("rst_wstrb", M_AXI_WSTRB, 4'hF);
        rst_n = 1'b1;
        @(negedge clk);
        check_eq("idle_cmd_ready", cmd_ready, 1);

        // 1: zero-wait, done on first poll
        clear_log(); done_on = 1; result_val = 32'h14;
        sb.push_back(model(32'h14));
        start_cmd(32'd3, t0);
        wait_rsp(t1);
        check_eq("t1_latency", t1 - t0, 9);
        check_eq("t1_nwrites", wr_addr_log.size(), 2);
        if (wr_addr_log.size() == 2) begin
            check_eq("t1_wr0_addr", wr_addr_log[0], c_BASE);
            check_eq("t1_wr0_data", wr_data_log[0], 32'd3);
            check_eq("t1_wr1_addr", wr_addr_log[1], c_BASE + 32'h4);
            check_eq("t1_wr1_data", wr_data_log[1], 32'd1);
        end
        check_eq("t1_stat_reads", stat_reads, 1);
        release_rsp();

        // 2: slow AW/W, done on 4th status read
        clear_log(); aw_delay = 2; w_delay = 5; done_on = 4; result_val = 32'h2A;
        sb.push_back(model(32'h2A));
        start_cmd(32'd7, t0);
        wait_rsp(t1);
        check_eq("t2_stat_reads", stat_reads, 4);
        check_eq("t2_nwrites", wr_addr_log.size(), 2);
        release_rsp();

        // 3: error response on the operand write
        clear_log(); aw_delay = 0; w_delay = 0; done_on = 1; bresp_err_op = 1'b1;
        sb.push_back(model(32'h99));
        start_cmd(32'd5, t0);
        wait_rsp(t1);
        check_eq("t3_nwrites", wr_addr_log.size(), 1);
        check_eq("t3_stat_reads", stat_reads, 0);
        release_rsp();

        // 4: done never reported
        clear_log(); bresp_err_op = 1'b0; done_on = 0;
        sb.push_back(model(32'h0));
        start_cmd(32'd6, t0);
        wait_rsp(t1);
        check_eq("t4_stat_reads", stat_reads, c_POLL_LIMIT);
        release_rsp();

        // 5: response back-pressure with a new command pending
        clear_log(); done_on = 1; result_val = 32'h55;
        sb.push_back(model(32'h55));
        start_cmd(32'd9, t0);
        wait_rsp(t1);
        result_val = 32'hAB;
        sb.push_back(model(32'hAB));
        cmd_valid = 1'b1; cmd_operand = 32'd10;
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (cmd_ready !== 1'b0 || rsp_valid !== 1'b1 ||
                rsp_result !== 32'h55 || rsp_code !== 2'b00) bad++;
        end
        check_eq("t5_hold_stable", bad, 0);
        release_rsp();
        check_eq("t5_ready_after_rsp", cmd_ready, 1);
        start_cmd(32'd10, t0);
        wait_rsp(t1);
        release_rsp();

        // 6: reset while a status read is in flight
        clear_log(); done_on = 0;
        start_cmd(32'd11, t0);
        n = 0;
        while (!M_AXI_ARVALID && n < 50) begin @(negedge clk); n++; end
        check_eq("t6_arvalid_seen", M_AXI_ARVALID, 1);
        #1 rst_n = 1'b0;
        #1;
        check_eq("t6_async_drop", {M_AXI_ARVALID, rsp_valid, cmd_ready, M_AXI_RREADY}, 0);
        check_eq("t6_araddr_rst", M_AXI_ARADDR, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        clear_log(); done_on = 1; result_val = 32'h77;
        sb.push_back(model(32'h77));
        start_cmd(32'd12, t0);
        wait_rsp(t1);
        check_eq("t6_latency", t1 - t0, 9);
        release_rsp();

        repeat (2) @(negedge clk);
        check_eq("protocol_violations", viol, 0);
        check_eq("sb_empty", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule : tb_exponent_axi4_lite_master
`default_nettype wire
